ice51_boot_ctrl: RTL and testbench

//  Boot sequencer between UART receiver, code memory and ice51 core. After reset, holds the core in reset.

---
 rtl/ice51_boot_ctrl.sv | 136 +++++++++++++
 tb/tb_ice51_boot_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ice51_boot_ctrl.sv
// Boot sequencer: loads MEM_SIZE UART bytes into code memory, then releases the ice51 core.
// Optional ICE51_BOOT_CHECKSUM_EN adds a mod-256 sum check (CHECK/ERR states) before release.
module ice51_boot_ctrl #(
  parameter int unsigned MEM_SIZE   = 512,
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned GAP_CYCLES = 20000,
  parameter bit          PRELOAD    = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  input  logic [ADDR_W-1:0] i_cpu_code_addr,
  output logic [ADDR_W-1:0] o_code_addr,
  output logic              o_code_we,
  output logic [7:0]        o_code_wdata,
  output logic              o_cpu_nrst,
  output logic              o_cpu_rx_valid,
  output logic [7:0]        o_cpu_rx_data,
  output logic              o_loading,
  output logic              o_boot_err
);

  localparam int unsigned       GapW     = $clog2(GAP_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(MEM_SIZE - 1);
  localparam logic [GapW-1:0]   GapLast  = GapW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StLoad, StCheck, StRun, StErr} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [GapW-1:0]   gap_q;
  logic              code_we_q;
  logic [7:0]        code_wdata_q;
  logic              cpu_nrst_q;
  logic              cpu_rx_valid_q;
  logic [7:0]        cpu_rx_data_q;
`ifdef ICE51_BOOT_CHECKSUM_EN
  logic [7:0]        sum_q;
  logic              boot_err_q;
`endif

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q        <= PRELOAD ? StRun : StLoad;
      ptr_q          <= '0;
      addr_q         <= '0;
      gap_q          <= '0;
      code_we_q      <= 1'b0;
      code_wdata_q   <= '0;
      cpu_nrst_q     <= PRELOAD;
      cpu_rx_valid_q <= 1'b0;
      cpu_rx_data_q  <= '0;
`ifdef ICE51_BOOT_CHECKSUM_EN
      sum_q          <= '0;
      boot_err_q     <= 1'b0;
`endif
    end else begin
      code_we_q      <= 1'b0;
      cpu_rx_valid_q <= 1'b0;
      case (state_q)
        StLoad: begin
          // Leave LOAD only once the final write pulse has completed.
          if (code_we_q && addr_q == LastAddr) begin
`ifdef ICE51_BOOT_CHECKSUM_EN
            state_q    <= StCheck;
`else
            state_q    <= StRun;
            cpu_nrst_q <= 1'b1;
`endif
          end else if (i_rx_valid) begin
            code_we_q    <= 1'b1;
            addr_q       <= ptr_q;
            code_wdata_q <= i_rx_data;
`ifdef ICE51_BOOT_CHECKSUM_EN
            sum_q        <= sum_q + i_rx_data;
`endif
            if (ptr_q != LastAddr) ptr_q <= ptr_q + ADDR_W'(1);
          end
        end
`ifdef ICE51_BOOT_CHECKSUM_EN
        StCheck: begin
          if (i_rx_valid) begin
            if (i_rx_data == sum_q) begin
              state_q    <= StRun;
              cpu_nrst_q <= 1'b1;
            end else begin
              state_q    <= StErr;
              boot_err_q <= 1'b1;
            end
          end
        end
`endif
        StRun: begin
          cpu_rx_valid_q <= i_rx_valid;
          if (i_rx_valid) cpu_rx_data_q <= i_rx_data;
        end
        default: ;
      endcase

      // Stalled transfer: restart from address 0 unless a byte arrives on the expiry cycle.
      if ((state_q == StLoad || state_q == StCheck) && ptr_q != '0) begin
        if (i_rx_valid) begin
          gap_q <= '0;
        end else if (gap_q == GapLast) begin
          gap_q   <= '0;
          ptr_q   <= '0;
          addr_q  <= '0;
          state_q <= StLoad;
`ifdef ICE51_BOOT_CHECKSUM_EN
          sum_q   <= '0;
`endif
        end else begin
          gap_q <= gap_q + GapW'(1);
        end
      end else begin
        gap_q <= '0;
      end
    end
  end

  assign o_code_addr    = (state_q == StRun) ? i_cpu_code_addr : addr_q;
  assign o_code_we      = code_we_q;
  assign o_code_wdata   = code_wdata_q;
  assign o_cpu_nrst     = cpu_nrst_q;
  assign o_cpu_rx_valid = cpu_rx_valid_q;
  assign o_cpu_rx_data  = cpu_rx_data_q;
  assign o_loading      = (state_q == StLoad) || (state_q == StCheck);
`ifdef ICE51_BOOT_CHECKSUM_EN
  assign o_boot_err     = boot_err_q;
`else
  assign o_boot_err     = 1'b0;
`endif

endmodule

// File: tb/tb_ice51_boot_ctrl.sv
// Randomized bench for ice51_boot_ctrl: byte-level load/run model with write and forward scoreboards.
// A second instance with PRELOAD=1 sees the same UART traffic and must forward every byte.
module tb_ice51_boot_ctrl;

  localparam int unsigned MemSize   = 32;
  localparam int unsigned AddrW     = 6;
  localparam int unsigned GapCycles = 64;

  localparam int PhLoad  = 0;
  localparam int PhCheck = 1;
  localparam int PhRun   = 2;
  localparam int PhErr   = 3;

  typedef struct packed {
    logic [AddrW-1:0] addr;
    logic [7:0]       data;
  } wr_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             rx_valid = 1'b0;
  logic [7:0]       rx_data = '0;
  logic [AddrW-1:0] cpu_addr = '0;

  logic [AddrW-1:0] code_addr, p_code_addr;
  logic             code_we, p_code_we;
  logic [7:0]       code_wdata, p_code_wdata;
  logic             cpu_nrst, p_cpu_nrst;
  logic             cpu_rx_valid, p_cpu_rx_valid;
  logic [7:0]       cpu_rx_data, p_cpu_rx_data;
  logic             loading, p_loading;
  logic             boot_err, p_boot_err;

  ice51_boot_ctrl #(
    .MEM_SIZE(MemSize), .ADDR_W(AddrW), .GAP_CYCLES(GapCycles), .PRELOAD(1'b0)
  ) u_dut (
    .i_clk(clk), .i_nrst(rst_n), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
    .i_cpu_code_addr(cpu_addr), .o_code_addr(code_addr), .o_code_we(code_we),
    .o_code_wdata(code_wdata), .o_cpu_nrst(cpu_nrst), .o_cpu_rx_valid(cpu_rx_valid),
    .o_cpu_rx_data(cpu_rx_data), .o_loading(loading), .o_boot_err(boot_err)
  );

  ice51_boot_ctrl #(
    .MEM_SIZE(MemSize), .ADDR_W(AddrW), .GAP_CYCLES(GapCycles), .PRELOAD(1'b1)
  ) u_dut_pre (
    .i_clk(clk), .i_nrst(rst_n), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
    .i_cpu_code_addr(cpu_addr), .o_code_addr(p_code_addr), .o_code_we(p_code_we),
    .o_code_wdata(p_code_wdata), .o_cpu_nrst(p_cpu_nrst), .o_cpu_rx_valid(p_cpu_rx_valid),
    .o_cpu_rx_data(p_cpu_rx_data), .o_loading(p_loading), .o_boot_err(p_boot_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  wr_t        dut_wr_q[$];
  wr_t        exp_wr_q[$];
  logic [7:0] dut_fwd_q[$];
  logic [7:0] exp_fwd_q[$];
  logic [7:0] pre_fwd_q[$];
  logic [7:0] pre_exp_q[$];
  int         pre_we_cnt = 0;
  int         last_we_cyc = 0;
  int         nrst_rise_cyc = 0;
  logic       nrst_prev = 1'b0;

  always @(negedge clk) begin
    if (code_we) begin
      dut_wr_q.push_back('{addr: code_addr, data: code_wdata});
      last_we_cyc = cyc;
    end
    if (cpu_rx_valid) dut_fwd_q.push_back(cpu_rx_data);
    if (p_cpu_rx_valid) pre_fwd_q.push_back(p_cpu_rx_data);
    if (p_code_we) pre_we_cnt++;
    if (cpu_nrst && !nrst_prev) nrst_rise_cyc = cyc;
    nrst_prev = cpu_nrst;
  end

  // Byte-level reference: which address each byte lands at, or whether the core sees it.
  int         m_phase;
  int         m_ptr;
  logic [7:0] m_sum;
  int         m_last_cyc;

  task automatic model_reset();
    m_phase    = PhLoad;
    m_ptr      = 0;
    m_sum      = 8'h00;
    m_last_cyc = cyc;
  endtask

  task automatic model_byte(input logic [7:0] b, input int scyc);
    int idle;
    idle       = scyc - m_last_cyc - 1;
    m_last_cyc = scyc;
    pre_exp_q.push_back(b);
    if ((m_phase == PhLoad || m_phase == PhCheck) && m_ptr > 0 && idle >= int'(GapCycles)) begin
      m_phase = PhLoad;
      m_ptr   = 0;
      m_sum   = 8'h00;
    end
    case (m_phase)
      PhLoad: begin
        exp_wr_q.push_back('{addr: AddrW'(m_ptr), data: b});
        m_sum = m_sum + b;
        m_ptr++;
`ifdef ICE51_BOOT_CHECKSUM_EN
        if (m_ptr == int'(MemSize)) m_phase = PhCheck;
`else
        if (m_ptr == int'(MemSize)) m_phase = PhRun;
`endif
      end
      PhCheck: m_phase = (b == m_sum) ? PhRun : PhErr;
      PhRun:   exp_fwd_q.push_back(b);
      default: ;
    endcase
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    model_byte(b, cyc);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check_val({tag, "_wr_count"}, 32'(dut_wr_q.size()), 32'(exp_wr_q.size()));
    n = (dut_wr_q.size() < exp_wr_q.size()) ? dut_wr_q.size() : exp_wr_q.size();
    for (int i = 0; i < n; i++) begin
      check_val($sformatf("%s_wr%0d_addr", tag, i), 32'(dut_wr_q[i].addr), 32'(exp_wr_q[i].addr));
      check_val($sformatf("%s_wr%0d_data", tag, i), 32'(dut_wr_q[i].data), 32'(exp_wr_q[i].data));
    end
    dut_wr_q.delete();
    exp_wr_q.delete();
  endtask

  task automatic compare_fwd(input string tag);
    int n;
    check_val({tag, "_fwd_count"}, 32'(dut_fwd_q.size()), 32'(exp_fwd_q.size()));
    n = (dut_fwd_q.size() < exp_fwd_q.size()) ? dut_fwd_q.size() : exp_fwd_q.size();
    for (int i = 0; i < n; i++)
      check_val($sformatf("%s_fwd%0d", tag, i), 32'(dut_fwd_q[i]), 32'(exp_fwd_q[i]));
    dut_fwd_q.delete();
    exp_fwd_q.delete();
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_val({tag, "_we"}, 32'(code_we), 32'h0);
    check_val({tag, "_wdata"}, 32'(code_wdata), 32'h0);
    check_val({tag, "_addr"}, 32'(code_addr), 32'h0);
    check_val({tag, "_cpu_nrst"}, 32'(cpu_nrst), 32'h0);
    check_val({tag, "_rx_valid"}, 32'(cpu_rx_valid), 32'h0);
    check_val({tag, "_rx_data"}, 32'(cpu_rx_data), 32'h0);
    check_val({tag, "_loading"}, 32'(loading), 32'h1);
    check_val({tag, "_boot_err"}, 32'(boot_err), 32'h0);
    check_val({tag, "_pre_cpu_nrst"}, 32'(p_cpu_nrst), 32'h1);
    check_val({tag, "_pre_loading"}, 32'(p_loading), 32'h0);
    idle(3);
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic load_all(input string tag);
    for (int i = 0; i < int'(MemSize); i++) begin
      send_byte(8'($urandom_range(0, 255)));
      if (i == int'(MemSize) / 2) check_val({tag, "_loading_mid"}, 32'(loading), 32'h1);
      idle(int'($urandom_range(2, 12)));
    end
    idle(4);
    compare_writes(tag);
    compare_fwd(tag);
  endtask

  initial begin
    logic [AddrW-1:0] a;
    logic [7:0]       b;

    do_reset("rst0");

    // Full load with random data and spacing.
    load_all("load");
`ifdef ICE51_BOOT_CHECKSUM_EN
    check_val("chk_hold_nrst", 32'(cpu_nrst), 32'h0);
    check_val("chk_loading", 32'(loading), 32'h1);
    send_byte(m_sum);
    idle(3);
    check_val("chk_good_nrst", 32'(cpu_nrst), 32'h1);
    check_val("chk_good_err", 32'(boot_err), 32'h0);
`else
    check_val("release_latency", 32'(nrst_rise_cyc - last_we_cyc), 32'd1);
`endif
    check_val("run_cpu_nrst", 32'(cpu_nrst), 32'h1);
    check_val("run_loading", 32'(loading), 32'h0);

    // RUN: bytes go to the core, memory port follows the core.
    send_byte(8'h5A);
    idle(3);
    for (int i = 0; i < 5; i++) begin
      send_byte(8'($urandom_range(0, 255)));
      idle(int'($urandom_range(1, 6)));
    end
    idle(3);
    compare_fwd("run");
    compare_writes("run");
    check_val("run_boot_err", 32'(boot_err), 32'h0);
    for (int i = 0; i < 4; i++) begin
      a = AddrW'($urandom_range(0, (1 << AddrW) - 1));
      cpu_addr = a;
      #1;
      check_val($sformatf("run_addr_mux%0d", i), 32'(code_addr), 32'(a));
    end

    // Reset in the middle of a load, then reload from address 0.
    do_reset("rst1");
    for (int i = 0; i < 10; i++) begin
      send_byte(8'($urandom_range(0, 255)));
      idle(int'($urandom_range(2, 12)));
    end
    compare_writes("preload_mid");
    do_reset("rst_mid");
    send_byte(8'($urandom_range(0, 255)));
    idle(3);
    compare_writes("after_rst");

    // Gap boundary: a byte on the expiry cycle is kept, one cycle later restarts.
    send_byte(8'($urandom_range(0, 255)));
    idle(3);
    send_byte(8'($urandom_range(0, 255)));
    idle(int'(GapCycles) - 2);
    send_byte(8'($urandom_range(0, 255)));
    idle(int'(GapCycles) - 1);
    send_byte(8'hA5);
    idle(3);
    b = 8'hFF;
    if (dut_wr_q.size() > 0) b = 8'(dut_wr_q[$].addr);
    check_val("gap_restart_addr", 32'(b), 32'h0);
    compare_writes("gap");
    idle(int'(GapCycles) + 20);
    send_byte(8'($urandom_range(0, 255)));
    idle(3);
    compare_writes("gap_long");
    compare_fwd("gap");

`ifdef ICE51_BOOT_CHECKSUM_EN
    // Bad checksum ends in ERR with the core held.
    do_reset("rst2");
    load_all("load_bad");
    send_byte(m_sum ^ 8'h01);
    idle(3);
    check_val("chk_bad_err", 32'(boot_err), 32'h1);
    check_val("chk_bad_nrst", 32'(cpu_nrst), 32'h0);
    send_byte(8'h33);
    idle(3);
    compare_writes("err");
    compare_fwd("err");
    check_val("chk_err_stays", 32'(boot_err), 32'h1);
`endif

    // PRELOAD instance never writes and forwards everything it received.
    check_val("pre_we_count", 32'(pre_we_cnt), 32'h0);
    check_val("pre_fwd_count", 32'(pre_fwd_q.size()), 32'(pre_exp_q.size()));
    for (int i = 0; i < pre_fwd_q.size() && i < pre_exp_q.size(); i++)
      check_val($sformatf("pre_fwd%0d", i), 32'(pre_fwd_q[i]), 32'(pre_exp_q[i]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
